demux_1to8_capture: RTL and testbench
=====================================

Name: demux_1to8_capture

Overview:
- Receiving end of the 8:1 select path: takes one serial bit per transfer plus its 3-bit slot select and demultiplexes it into slot `sel` of an 8-bit frame register.
- Tracks which slots have been written. Once all 8 are filled, presents the assembled frame on a valid/ready output handshake.
- Used to rebuild the parallel word that the 8:1 mux path serialises.

Parameters:
- N, 8, number of output slots (power of two; only 8 is verified).
- SEL_W, 3, select width, equals log2(N).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  din/sel are valid this cycle
- in_ready  output  1  block can accept a transfer
- din  input  1  serial data bit
- sel  input  SEL_W  destination slot index
- flush  input  1  discard the partial frame
- out_valid  output  1  assembled frame is available
- out_ready  input  1  consumer accepts the frame
- out_data  output  N  assembled frame; bit i is the value written with sel=i
- fill_mask  output  N  bit i set when slot i has been written in the current frame
- dup_err  output  1  duplicate-write pulse (tied 0 unless DEMUX_DUP_ERR_EN is defined)

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset (rst high at a clk edge):
  - State = FILL.
  - out_valid=0, out_data=0, fill_mask=0, dup_err=0.
  - in_ready=0 while rst is high, 1 from the first cycle after release.
- States: FILL, DONE.
- FILL:
  - in_ready=1, out_valid=0.
  - An accept is in_valid & in_ready at the edge: out_data[sel] <= din and fill_mask[sel] <= 1.
  - If fill_mask including this write is all ones, go to DONE. out_valid is high the cycle after the 8th distinct slot is written (latency 1).
- DONE:
  - in_ready=0, out_valid=1, out_data held stable.
  - in_valid is ignored; no data or mask change.
  - On out_valid & out_ready: next cycle out_data=0, fill_mask=0, state=FILL, in_ready=1.
  - There is no same-cycle bypass: a new input is accepted no earlier than the cycle after the handshake.
- Slot order: slots may be written in any order. Writing an already-filled slot overwrites its data bit, leaves fill_mask unchanged and does not advance completion.
- flush:
  - In FILL, clears out_data and fill_mask next cycle. A simultaneous input write is dropped.
  - In DONE, flush is ignored; a complete frame is never discarded except by rst.
- Priority: rst > flush > output handshake > input write.
- Reset mid-frame discards all partial data.
- fill_mask is a registered output, visible one cycle after each write.
- sel is always in range because N=2^SEL_W, so there is no out-of-range case.

Optional Feature:
- Macro: DEMUX_DUP_ERR_EN.
- Defined:
  - dup_err pulses high for exactly one cycle, the cycle after an accepted write whose sel slot already has fill_mask[sel]=1.
  - The overwrite still occurs.
  - No pulse for writes dropped by flush.
- Undefined: dup_err is constant 0 and the detection logic is not built.

Decomposition:
- Package demux_pkg:
  - localparam N=8, SEL_W=3.
  - State enum typedef (FILL, DONE).
  - Frame and mask typedef of width N.
- One sub-module, demux_slot_decode: SEL_W-to-N one-hot decoder with enable, used for both the data write strobe and the mask set. The rest stays in the top.

Test Plan:
- In-order fill: after reset, write sel 0..7 with din = 0,1,0,1,0,1,0,1 on consecutive cycles, out_ready=1 → out_valid high one cycle after the sel=7 write, out_data=8'hAA. The next cycle has fill_mask=0 and in_ready=1.
- Out-of-order fill: sel order 7,3,0,5,1,6,2,4 with din=1 for slots 0-3 and 0 otherwise → out_data=8'h0F, out_valid only after the 8th write. fill_mask steps as expected each cycle.
- Backpressure: complete a frame of 8'hFF with out_ready=0 for 5 cycles and in_valid held high with din=0 → out_data stays 8'hFF, in_ready=0 and fill_mask=8'hFF throughout. Raising out_ready gives one handshake, then FILL.
- Duplicate write (DEMUX_DUP_ERR_EN defined): write sel=2 din=1, then sel=2 din=0 → dup_err pulses once, out_data[2]=0 and fill_mask=8'h04. With the macro undefined, dup_err stays 0.
- Flush and reset: after 5 writes, assert flush together with a sel=5 write → fill_mask=0 and out_data=0 next cycle, sel=5 not stored. Repeat with rst instead; all outputs return to reset values and in_ready=0 during rst.

Source files
------------

// File: rtl/demux_pkg.sv
// -----------------------------------------------------------------------------
// demux_pkg
// Shared types and sizing for the 1:8 serial-to-parallel capture block.
// -----------------------------------------------------------------------------
package demux_pkg;

    // Number of frame slots and the select width that addresses them.
    localparam int N     = 8;
    localparam int SEL_W = 3;

    // Capture state: gathering slots, or holding a complete frame.
    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_DONE = 1'b1
    } state_e;

    // Assembled frame and the per-slot written mask.
    typedef logic [N-1:0] frame_t;
    typedef logic [N-1:0] mask_t;

    // A frame is complete once every slot has been written at least once.
    function automatic logic mask_full(input mask_t m);
        return &m;
    endfunction

endpackage : demux_pkg

// File: rtl/demux_1to8_capture_if.sv
// -----------------------------------------------------------------------------
// demux_1to8_capture_if
// Bundles the serial input handshake, flush, and the frame output handshake.
// master: the environment (producer of bits, consumer of frames).
// slave : the capture block itself.
// -----------------------------------------------------------------------------
interface demux_1to8_capture_if;
    import demux_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic             din;
    logic [SEL_W-1:0] sel;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    frame_t           out_data;
    mask_t            fill_mask;
    logic             dup_err;

    modport master (
        output in_valid,
        output din,
        output sel,
        output flush,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  fill_mask,
        input  dup_err
    );

    modport slave (
        input  in_valid,
        input  din,
        input  sel,
        input  flush,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output fill_mask,
        output dup_err
    );

endinterface : demux_1to8_capture_if

// File: rtl/demux_slot_decode.sv
// -----------------------------------------------------------------------------
// demux_slot_decode
// SEL_W-to-N one-hot decoder with enable. The single one-hot result serves as
// both the data write strobe and the fill-mask set vector, so the two can
// never disagree about which slot a transfer targets.
// -----------------------------------------------------------------------------
module demux_slot_decode
    import demux_pkg::*;
(
    input  logic             en_i,
    input  logic [SEL_W-1:0] sel_i,
    output mask_t            onehot_o
);

    // Raise exactly one strobe bit for an enabled transfer, none otherwise.
    always_comb begin
        onehot_o = {N{1'b0}};
        if (en_i) begin
            onehot_o[sel_i] = 1'b1;
        end else begin
            onehot_o = {N{1'b0}};
        end
    end

endmodule : demux_slot_decode

// File: rtl/demux_1to8_capture.sv
// -----------------------------------------------------------------------------
// demux_1to8_capture
// Rebuilds an 8-bit word from serial bits, each tagged with its slot index.
// Slots may arrive in any order; once every slot has been written the frame is
// held on a valid/ready output until the consumer takes it.
//
// Build option:
//   DEMUX_DUP_ERR_EN - when defined, dup_err pulses for one cycle after an
//                      accepted write to a slot that was already filled.
//                      When undefined dup_err is tied low and no detection
//                      logic exists.
//
// Priority of controls: rst > flush (FILL only) > output handshake > write.
// -----------------------------------------------------------------------------
module demux_1to8_capture
    import demux_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    demux_1to8_capture_if.slave  bus
);

    state_e state_q, state_d;
    frame_t out_data_q, out_data_d;
    mask_t  fill_mask_q, fill_mask_d;

    logic   in_ready_s;
    logic   accept_s;
    logic   write_s;
    mask_t  strobe_s;
    mask_t  mask_set_s;

    // in_ready comes straight from the state flop, gated by reset so that it
    // is low for the whole time rst is high and high on the first cycle after.
    always_comb begin
        in_ready_s = 1'b0;
        if (rst) begin
            in_ready_s = 1'b0;
        end else if (state_q == ST_FILL) begin
            in_ready_s = 1'b1;
        end else begin
            in_ready_s = 1'b0;
        end
    end

    // A flush in FILL wins over a simultaneous input, so such a write is
    // dropped before it can reach the slot strobes.
    always_comb begin
        accept_s = bus.in_valid & in_ready_s;
        write_s  = 1'b0;
        if (accept_s && !bus.flush) begin
            write_s = 1'b1;
        end else begin
            write_s = 1'b0;
        end
    end

    demux_slot_decode u_slot_decode (
        .en_i     (write_s),
        .sel_i    (bus.sel),
        .onehot_o (strobe_s)
    );

    // Mask as it will look once this cycle's write lands.
    always_comb begin
        mask_set_s = fill_mask_q | strobe_s;
    end

    // Next-state, frame and mask update for the FILL/DONE controller.
    always_comb begin
        state_d     = state_q;
        out_data_d  = out_data_q;
        fill_mask_d = fill_mask_q;
        case (state_q)
            ST_FILL: begin
                if (bus.flush) begin
                    out_data_d  = {N{1'b0}};
                    fill_mask_d = {N{1'b0}};
                    state_d     = ST_FILL;
                end else if (write_s) begin
                    // Overwrite only the strobed slot; a repeat write just
                    // replaces the bit and leaves the mask where it was.
                    out_data_d  = (out_data_q & ~strobe_s) | (strobe_s & {N{bus.din}});
                    fill_mask_d = mask_set_s;
                    if (mask_full(mask_set_s)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_FILL;
                    end
                end else begin
                    state_d = ST_FILL;
                end
            end
            ST_DONE: begin
                // Input and flush are ignored; only the consumer can release
                // a complete frame.
                if (bus.out_ready) begin
                    out_data_d  = {N{1'b0}};
                    fill_mask_d = {N{1'b0}};
                    state_d     = ST_FILL;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                out_data_d  = {N{1'b0}};
                fill_mask_d = {N{1'b0}};
                state_d     = ST_FILL;
            end
        endcase
    end

    // State, frame and mask registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_FILL;
            out_data_q  <= {N{1'b0}};
            fill_mask_q <= {N{1'b0}};
        end else begin
            state_q     <= state_d;
            out_data_q  <= out_data_d;
            fill_mask_q <= fill_mask_d;
        end
    end

`ifdef DEMUX_DUP_ERR_EN
    logic dup_err_q, dup_err_d;

    // A duplicate is an accepted (not flushed) write to an already-filled slot.
    always_comb begin
        dup_err_d = 1'b0;
        if (write_s && (|(fill_mask_q & strobe_s))) begin
            dup_err_d = 1'b1;
        end else begin
            dup_err_d = 1'b0;
        end
    end

    // One-cycle duplicate pulse register.
    always_ff @(posedge clk) begin
        if (rst) begin
            dup_err_q <= 1'b0;
        end else begin
            dup_err_q <= dup_err_d;
        end
    end

    assign bus.dup_err = dup_err_q;
`else
    assign bus.dup_err = 1'b0;
`endif

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.out_data  = out_data_q;
    assign bus.fill_mask = fill_mask_q;

endmodule : demux_1to8_capture

// File: tb/tb_demux_1to8_capture.sv
// -----------------------------------------------------------------------------
// tb_demux_1to8_capture
// Table-driven fills plus hand-written backpressure, flush, reset and
// duplicate-write sequences. Completed frames are queued when the completing
// write is driven and compared when the output handshake happens.
// -----------------------------------------------------------------------------
module tb_demux_1to8_capture;
    import demux_pkg::*;

`ifdef DEMUX_DUP_ERR_EN
    localparam logic DUP_EN = 1'b1;
`else
    localparam logic DUP_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    logic [7:0] sb_q[$];

    demux_1to8_capture_if bus ();

    demux_1to8_capture dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       in_valid;
        logic [2:0] sel;
        logic       din;
        logic       flush;
        logic       out_ready;
        logic       push;
        logic [7:0] push_val;
        logic [7:0] exp_mask;
        logic       exp_ov;
        logic       exp_ir;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] s, input logic d,
                         input logic f, input logic r);
        bus.in_valid  = v;
        bus.sel       = s;
        bus.din       = d;
        bus.flush     = f;
        bus.out_ready = r;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [7:0] mask, input logic ov,
                             input logic ir, input logic [7:0] data, input logic dup);
        chk({tag, "_mask"},  {24'd0, bus.fill_mask}, {24'd0, mask});
        chk({tag, "_valid"}, {31'd0, bus.out_valid}, {31'd0, ov});
        chk({tag, "_ready"}, {31'd0, bus.in_ready},  {31'd0, ir});
        chk({tag, "_data"},  {24'd0, bus.out_data},  {24'd0, data});
        chk({tag, "_dup"},   {31'd0, bus.dup_err},   {31'd0, dup});
    endtask

    function automatic vec_t mk(input logic v, input logic [2:0] s, input logic d,
                                input logic f, input logic r, input logic p,
                                input logic [7:0] pv, input logic [7:0] m,
                                input logic ov, input logic ir, input logic [7:0] dat);
        vec_t t;
        t.in_valid = v; t.sel = s; t.din = d; t.flush = f; t.out_ready = r;
        t.push = p; t.push_val = pv;
        t.exp_mask = m; t.exp_ov = ov; t.exp_ir = ir; t.exp_data = dat;
        return t;
    endfunction

    // Scoreboard: a handshake is seen on the negedge before the edge that takes it.
    always @(negedge clk) begin
        if (!rst && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected_frame actual=%0h required=none", bus.out_data);
            end else begin
                chk("sb_frame", {24'd0, bus.out_data}, {24'd0, sb_q.pop_front()});
            end
        end
    end

    // Watchdog so a stuck run still ends.
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // In-order fill, din alternating 0/1 -> 8'hAA, then handshake.
        vecs.push_back(mk(1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h01, 1'b0, 1'b1, 8'h00));
        vecs.push_back(mk(1'b1, 3'd1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h03, 1'b0, 1'b1, 8'h02));
        vecs.push_back(mk(1'b1, 3'd2, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h07, 1'b0, 1'b1, 8'h02));
        vecs.push_back(mk(1'b1, 3'd3, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h0F, 1'b0, 1'b1, 8'h0A));
        vecs.push_back(mk(1'b1, 3'd4, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h1F, 1'b0, 1'b1, 8'h0A));
        vecs.push_back(mk(1'b1, 3'd5, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h3F, 1'b0, 1'b1, 8'h2A));
        vecs.push_back(mk(1'b1, 3'd6, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h7F, 1'b0, 1'b1, 8'h2A));
        vecs.push_back(mk(1'b1, 3'd7, 1'b1, 1'b0, 1'b1, 1'b1, 8'hAA, 8'hFF, 1'b1, 1'b0, 8'hAA));
        vecs.push_back(mk(1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 8'h00));
        // Out-of-order fill 7,3,0,5,1,6,2,4; slots 0-3 get 1 -> 8'h0F.
        vecs.push_back(mk(1'b1, 3'd7, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h80, 1'b0, 1'b1, 8'h00));
        vecs.push_back(mk(1'b1, 3'd3, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h88, 1'b0, 1'b1, 8'h08));
        vecs.push_back(mk(1'b1, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h89, 1'b0, 1'b1, 8'h09));
        vecs.push_back(mk(1'b1, 3'd5, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'hA9, 1'b0, 1'b1, 8'h09));
        vecs.push_back(mk(1'b1, 3'd1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'hAB, 1'b0, 1'b1, 8'h0B));
        vecs.push_back(mk(1'b1, 3'd6, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'hEB, 1'b0, 1'b1, 8'h0B));
        vecs.push_back(mk(1'b1, 3'd2, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'hEF, 1'b0, 1'b1, 8'h0F));
        vecs.push_back(mk(1'b1, 3'd4, 1'b0, 1'b0, 1'b1, 1'b1, 8'h0F, 8'hFF, 1'b1, 1'b0, 8'h0F));
        vecs.push_back(mk(1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 8'h00));

        // Reset state.
        drive(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        cyc();
        cyc();
        check_out("reset", 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        rst = 1'b0;
        #1;
        chk("reset_release_ready", {31'd0, bus.in_ready}, 32'd1);

        // Table-driven fills.
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].in_valid, vecs[i].sel, vecs[i].din, vecs[i].flush, vecs[i].out_ready);
            if (vecs[i].push) begin
                sb_q.push_back(vecs[i].push_val);
            end
            cyc();
            check_out($sformatf("v%0d", i), vecs[i].exp_mask, vecs[i].exp_ov,
                      vecs[i].exp_ir, vecs[i].exp_data, 1'b0);
        end

        // Backpressure: frame 8'hFF held while in_valid/din=0 keeps pushing.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 3'(i), 1'b1, 1'b0, 1'b0);
            if (i == 7) begin
                sb_q.push_back(8'hFF);
            end
            cyc();
        end
        check_out("bp_full", 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b0);
        for (int k = 0; k < 5; k++) begin
            // One of the held cycles also carries flush, which must be ignored.
            drive(1'b1, 3'(k), 1'b0, (k == 2), 1'b0);
            cyc();
            check_out($sformatf("bp_hold%0d", k), 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b0);
        end
        // Handshake with in_valid still high: no same-cycle bypass.
        drive(1'b1, 3'd1, 1'b1, 1'b0, 1'b1);
        cyc();
        check_out("bp_release", 8'h00, 1'b0, 1'b1, 8'h00, 1'b0);
        drive(1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
        cyc();
        check_out("bp_after", 8'h00, 1'b0, 1'b1, 8'h00, 1'b0);

        // Flush mid-frame drops the simultaneous sel=5 write.
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 3'(i), 1'b1, 1'b0, 1'b1);
            cyc();
        end
        check_out("fl_partial", 8'h1F, 1'b0, 1'b1, 8'h1F, 1'b0);
        drive(1'b1, 3'd5, 1'b1, 1'b1, 1'b1);
        cyc();
        check_out("fl_clear", 8'h00, 1'b0, 1'b1, 8'h00, 1'b0);
        drive(1'b1, 3'd5, 1'b1, 1'b0, 1'b1);
        cyc();
        check_out("fl_rewrite", 8'h20, 1'b0, 1'b1, 8'h20, 1'b0);
        drive(1'b0, 3'd0, 1'b0, 1'b1, 1'b1);
        cyc();
        check_out("fl_idle", 8'h00, 1'b0, 1'b1, 8'h00, 1'b0);

        // Reset mid-frame discards everything.
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 3'(i), 1'b1, 1'b0, 1'b1);
            cyc();
        end
        drive(1'b1, 3'd5, 1'b1, 1'b0, 1'b1);
        rst = 1'b1;
        cyc();
        check_out("rst_mid", 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        drive(1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
        rst = 1'b0;
        #1;
        chk("rst_mid_release_ready", {31'd0, bus.in_ready}, 32'd1);
        cyc();
        check_out("rst_after", 8'h00, 1'b0, 1'b1, 8'h00, 1'b0);

        // Duplicate write to slot 2.
        drive(1'b1, 3'd2, 1'b1, 1'b0, 1'b1);
        cyc();
        check_out("dup_first", 8'h04, 1'b0, 1'b1, 8'h04, 1'b0);
        drive(1'b1, 3'd2, 1'b0, 1'b0, 1'b1);
        cyc();
        check_out("dup_second", 8'h04, 1'b0, 1'b1, 8'h00, DUP_EN);
        drive(1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
        cyc();
        check_out("dup_idle", 8'h04, 1'b0, 1'b1, 8'h00, 1'b0);
        // A would-be duplicate dropped by flush raises no pulse.
        drive(1'b1, 3'd2, 1'b1, 1'b1, 1'b1);
        cyc();
        check_out("dup_flushed", 8'h00, 1'b0, 1'b1, 8'h00, 1'b0);
        drive(1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
        cyc();
        check_out("dup_end", 8'h00, 1'b0, 1'b1, 8'h00, 1'b0);

        chk("sb_drained", sb_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_demux_1to8_capture
